// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Generic pipeline stage register. It carries one payload / control /
//   destination bundle per beat between two pipeline stages using a
//   valid/ready handshake. It stalls without losing beats and squashes every
//   held beat on flush. An empty or squashed stage shows all-zero control and
//   destination, so the downstream stage sees a NOP bubble. A saturating
//   counter records how many beats were discarded by flushes.
//
// Configuration macro:
//   PIPE_STAGE_SKID_EN
//     defined   : two entries (head + skid). in_ready comes straight from a
//                 flop, so there is no combinational path from out_ready to
//                 in_ready. occ ranges over 0..2.
//     undefined : single head entry. in_ready is combinational from
//                 out_ready, so a beat can be accepted in the same edge that
//                 releases the current head. occ ranges over 0..1.
//
// Parameters:
//   DATA_W  payload width (PC, ALU result, operands, ...)
//   CTRL_W  control word width
//   DEST_W  destination register index width
//   CNT_W   squash counter width
//
// Ports:
//   clk           in   clock, every state update happens on the rising edge
//   reset         in   asynchronous active-high reset
//   flush         in   synchronous squash of every held beat
//   in_valid      in   upstream beat present
//   in_ready      out  stage accepts a beat this cycle
//   in_data       in   upstream payload
//   in_ctrl       in   upstream control word
//   in_dest       in   upstream destination index
//   out_valid     out  beat presented downstream
//   out_ready     in   downstream accepts the beat
//   out_data      out  head payload (keeps its last value while empty)
//   out_ctrl      out  head control, zero while out_valid is low
//   out_dest      out  head destination, zero while out_valid is low
//   occ           out  number of held beats
//   squash_count  out  saturating count of beats discarded by flush
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 44,
  parameter int DEST_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  squash_count
);

  // Head entry: the oldest beat, always the one presented downstream.
  logic              r_headValid;
  logic [DATA_W-1:0] r_headData;
  logic [CTRL_W-1:0] r_headCtrl;
  logic [DEST_W-1:0] r_headDest;

  // Saturating squash counter.
  logic [CNT_W-1:0]  r_squashCount;

  // Handshake and next-state wires shared by both build variants.
  logic              w_inReady;
  logic              w_accept;
  logic              w_release;
  logic              w_headValidNxt;
  logic              w_headLoadIn;
  logic [1:0]        w_occ;
  logic [CNT_W:0]    w_cntSum;

  // A beat moves in when upstream offers and we are ready; a beat leaves
  // when we present one and downstream takes it. During flush a release is
  // still seen here, but the flush branch below discards the head anyway,
  // so that beat is counted as squashed rather than delivered.
  assign w_accept  = in_valid && w_inReady;
  assign w_release = r_headValid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

  // Skid entry: holds the younger beat captured while the head was stalled.
  logic              r_skidValid;
  logic [DATA_W-1:0] r_skidData;
  logic [CTRL_W-1:0] r_skidCtrl;
  logic [DEST_W-1:0] r_skidDest;

  logic              w_skidValidNxt;
  logic              w_headLoadSkid;
  logic              w_skidLoad;

  // Ready depends only on the registered skid flag, so out_ready never
  // reaches in_ready combinationally. While the skid is empty there is
  // always somewhere to put a new beat, even if the head is stalled.
  assign w_inReady = !flush && !r_skidValid;
  assign w_occ     = {1'b0, r_headValid} + {1'b0, r_skidValid};

  // Next-state selection for the two entries. The skid is only ever full
  // while the head is full, and while the skid is full in_ready is low, so
  // "release with skid full" never coincides with an accept.
  always_comb begin
    w_headValidNxt = r_headValid;
    w_skidValidNxt = r_skidValid;
    w_headLoadIn   = 1'b0;
    w_headLoadSkid = 1'b0;
    w_skidLoad     = 1'b0;
    if (flush) begin
      w_headValidNxt = 1'b0;
      w_skidValidNxt = 1'b0;
    end else if (!r_headValid) begin
      w_headValidNxt = w_accept;
      w_headLoadIn   = w_accept;
    end else if (w_release) begin
      if (r_skidValid) begin
        w_headValidNxt = 1'b1;
        w_skidValidNxt = 1'b0;
        w_headLoadSkid = 1'b1;
      end else begin
        w_headValidNxt = w_accept;
        w_headLoadIn   = w_accept;
      end
    end else begin
      w_skidLoad     = w_accept;
      w_skidValidNxt = r_skidValid || w_accept;
    end
  end

  // Valid flags for head and skid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_headValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else begin
      r_headValid <= w_headValidNxt;
      r_skidValid <= w_skidValidNxt;
    end
  end

  // Head payload: loads either a fresh upstream beat or the older beat
  // waiting in the skid. It is left alone otherwise, so out_data keeps its
  // last value while the stage is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_headData <= '0;
      r_headCtrl <= '0;
      r_headDest <= '0;
    end else if (w_headLoadIn) begin
      r_headData <= in_data;
      r_headCtrl <= in_ctrl;
      r_headDest <= in_dest;
    end else if (w_headLoadSkid) begin
      r_headData <= r_skidData;
      r_headCtrl <= r_skidCtrl;
      r_headDest <= r_skidDest;
    end
  end

  // Skid payload: captures the upstream beat that arrives while the head is
  // stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skidData <= '0;
      r_skidCtrl <= '0;
      r_skidDest <= '0;
    end else if (w_skidLoad) begin
      r_skidData <= in_data;
      r_skidCtrl <= in_ctrl;
      r_skidDest <= in_dest;
    end
  end

`else

  // Single-entry stage: we can take a beat when empty, or when the current
  // head leaves in the same edge.
  assign w_inReady = !flush && (!r_headValid || out_ready);
  assign w_occ     = {1'b0, r_headValid};

  // Next-state for the head flag. An accept wins over a release because the
  // new beat replaces the departing one in the same edge.
  always_comb begin
    w_headValidNxt = r_headValid;
    w_headLoadIn   = 1'b0;
    if (flush) begin
      w_headValidNxt = 1'b0;
    end else if (w_accept) begin
      w_headValidNxt = 1'b1;
      w_headLoadIn   = 1'b1;
    end else if (w_release) begin
      w_headValidNxt = 1'b0;
    end
  end

  // Head valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_headValid <= 1'b0;
    end else begin
      r_headValid <= w_headValidNxt;
    end
  end

  // Head payload: only written on accept, so out_data keeps its last value
  // while the stage is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_headData <= '0;
      r_headCtrl <= '0;
      r_headDest <= '0;
    end else if (w_headLoadIn) begin
      r_headData <= in_data;
      r_headCtrl <= in_ctrl;
      r_headDest <= in_dest;
    end
  end

`endif

  // Sum one bit wider than the counter so overflow shows up in the top bit.
  assign w_cntSum = {1'b0, r_squashCount} + {{(CNT_W-1){1'b0}}, w_occ};

  // Squash counter: every beat held at a flush edge is counted, including a
  // head that downstream happened to accept in that same edge. It saturates
  // at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_squashCount <= '0;
    end else if (flush) begin
      if (w_cntSum[CNT_W]) begin
        r_squashCount <= '1;
      end else begin
        r_squashCount <= w_cntSum[CNT_W-1:0];
      end
    end
  end

  // Outputs come only from flops (plus the ready logic), so no in_* input
  // reaches out_*. Control and destination are gated to zero while empty so
  // an idle or squashed stage looks like a NOP bubble.
  assign in_ready     = w_inReady;
  assign out_valid    = r_headValid;
  assign out_data     = r_headData;
  assign out_ctrl     = r_headValid ? r_headCtrl : '0;
  assign out_dest     = r_headValid ? r_headDest : '0;
  assign occ          = w_occ;
  assign squash_count = r_squashCount;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Purpose:
//   Self-checking bench for pipe_stage_reg. A queue-based model of the
//   stage (FIFO of beats with capacity 1 or 2) predicts every output each
//   cycle; directed literal checks pin the model at key points. Follows
//   PIPE_STAGE_SKID_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 44;
  localparam int DEST_W = 3;
  localparam int CNT_W  = 2;
  localparam int MAXCNT = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DEST_W-1:0] out_dest;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  squash_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [DEST_W-1:0] dest;
  } beat_t;

  beat_t mq[$];
  int    modelCnt = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .DEST_W(DEST_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .out_dest    (out_dest),
    .occ         (occ),
    .squash_count(squash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whether the stage should take a beat now, from occupancy and the rules
  // of each mode.
  function automatic bit expReady();
    if (flush) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic int satAdd(input int a, input int b);
    return (a + b > MAXCNT) ? MAXCNT : a + b;
  endfunction

  function automatic beat_t mkBeat();
    beat_t b;
    b.data = in_data;
    b.ctrl = in_ctrl;
    b.dest = in_dest;
    return b;
  endfunction

  // Model: a FIFO of beats. Flush empties it and counts what was held;
  // otherwise the head pops on release and the offered beat is pushed on
  // accept.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      modelCnt <= 0;
    end else if (flush) begin
      modelCnt <= satAdd(modelCnt, mq.size());
      mq.delete();
    end else if (mq.size() != 0 && out_ready && in_valid && expReady()) begin
      void'(mq.pop_front());
      mq.push_back(mkBeat());
    end else if (mq.size() != 0 && out_ready) begin
      void'(mq.pop_front());
    end else if (in_valid && expReady()) begin
      mq.push_back(mkBeat());
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("out_data", 64'(out_data), 64'(mq[0].data));
      checkOutput("out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
      checkOutput("out_dest", 64'(out_dest), 64'(mq[0].dest));
    end else begin
      checkOutput("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
      checkOutput("out_dest_bubble", 64'(out_dest), 64'd0);
    end
    checkOutput("occ", 64'(occ), 64'(mq.size()));
    checkOutput("squash_count", 64'(squash_count), 64'(modelCnt));
    checkOutput("in_ready", 64'(in_ready), 64'(expReady()));
  end

  // Drive one cycle of inputs, with all fields derived from beat number n,
  // then step to just after the next rising edge.
  task automatic applyStimulus(input logic v, input int n, input logic ordy,
                               input logic fl);
    in_valid  = v;
    in_data   = 64'(n);
    in_ctrl   = 44'(n * 7 + 3);
    in_dest   = 3'(n % 8);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  int satExp[3];

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 44'h123;
    in_dest   = 3'd5;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a beat offered: nothing is taken and everything is zero.
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("rst_out_dest", 64'(out_dest), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_occ", 64'(occ), 64'd0);
    checkOutput("rst_squash", 64'(squash_count), 64'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Streaming 1..8 back to back with downstream always ready.
    applyStimulus(1'b1, 1, 1'b1, 1'b0);
    checkOutput("stream_first_data", 64'(out_data), 64'd1);
    checkOutput("stream_first_dest", 64'(out_dest), 64'd1);
    for (int n = 2; n <= 8; n++) applyStimulus(1'b1, n, 1'b1, 1'b0);
    checkOutput("stream_last_data", 64'(out_data), 64'd8);
    checkOutput("stream_last_dest", 64'(out_dest), 64'd0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("stream_drained", 64'(out_valid), 64'd0);

    // Stall: 5 becomes the head, then downstream stops while 6 is offered.
    for (int n = 1; n <= 4; n++) applyStimulus(1'b1, n, 1'b1, 1'b0);
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    applyStimulus(1'b1, 6, 1'b0, 1'b0);
    checkOutput("stall_head", 64'(out_data), 64'd5);
    checkOutput("stall_occ", 64'(occ), SKID ? 64'd2 : 64'd1);
    checkOutput("stall_ready_lo", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("stall_ready_follow", 64'(in_ready), SKID ? 64'd0 : 64'd1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 6, 1'b1, 1'b0);
    checkOutput("stall_then6", 64'(out_data), 64'd6);
    applyStimulus(1'b1, 7, 1'b1, 1'b0);
    applyStimulus(1'b1, 8, 1'b1, 1'b0);
    checkOutput("stall_then8", 64'(out_data), 64'd8);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Flush at full occupancy with a beat offered and a coinciding release.
    applyStimulus(1'b1, 9, 1'b0, 1'b0);
    applyStimulus(1'b1, 10, 1'b0, 1'b0);
    applyStimulus(1'b1, 11, 1'b1, 1'b1);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("flush_dest", 64'(out_dest), 64'd0);
    checkOutput("flush_occ", 64'(occ), 64'd0);
    checkOutput("flush_count", 64'(squash_count), SKID ? 64'd2 : 64'd1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("flush_no_accept", 64'(occ), 64'd0);

    // Reset in the middle of a stall discards everything at once.
    applyStimulus(1'b1, 12, 1'b0, 1'b0);
    applyStimulus(1'b1, 13, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_occ", 64'(occ), 64'd0);
    checkOutput("midrst_count", 64'(squash_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Counter saturation: repeated flushes at full occupancy.
    if (SKID) begin
      satExp[0] = 2; satExp[1] = 3; satExp[2] = 3;
    end else begin
      satExp[0] = 1; satExp[1] = 2; satExp[2] = 3;
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 20 + k, 1'b0, 1'b0);
      applyStimulus(1'b1, 30 + k, 1'b0, 1'b0);
      applyStimulus(1'b1, 40 + k, 1'b0, 1'b1);
      checkOutput("sat_count", 64'(squash_count), 64'(satExp[k]));
    end

    // Short tail of traffic after the flushes.
    for (int n = 50; n < 54; n++) applyStimulus(1'b1, n, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
